// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width, and the baud
// timing helpers used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_state_t;

  // Clock cycles per serial symbol (integer truncation).
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Cycles from a start-bit edge to the middle of the start bit.
  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs. Both flops
// reset to RESET_VAL so an idle-high line reads idle right after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-deep output register and valid/ready output.
// Optional build macro: UART_RX_MAJORITY_VOTE_EN (3-sample majority vote on
// every start/data/stop sample); undefined gives a single mid-bit sample.
//
// Handshake: data_out_valid stays high with data_out stable until a cycle
// where data_out_valid && data_out_ready; that cycle consumes the byte. The
// line is never back-pressured: a byte completing while the register is
// still full is dropped and overrun pulses for one cycle.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_error,
  output logic       overrun,
  output logic [2:0] o_dbg_state
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The third vote lands one count past the nominal point, so the counter
  // must reach SYMBOL_EDGE_TIME and restarts at 1 to keep bit spacing exact.
  localparam int CNT_W = $clog2(SYMBOL_EDGE_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_RESTART = CNT_W'(1);
`else
  localparam int CNT_W = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CNT_W-1:0] CNT_RESTART = '0;
`endif

  uart_state_t               r_state;
  uart_state_t               w_next_state;
  logic                      w_rx_sync;
  logic                      r_rx_prev;
  logic [1:0]                r_primed;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_n;
  logic [2:0]                r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      w_fall;
  logic                      w_sample_pt;
  logic                      w_bit;
  logic                      w_cnt_clr;
  logic                      w_shift_en;
  logic                      w_deliver;
  logic                      w_frame_err;
  logic                      w_consume;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .i_d (serial_in),
    .o_q (w_rx_sync)
  );

  // Nominal sample count: mid start bit, then one full symbol per bit.
  assign w_n = (r_state == ST_START) ? CNT_W'(SAMPLE_TIME - 1) : CNT_W'(SYMBOL_EDGE_TIME - 1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] r_vote;

  // Capture the votes at N-1 and N; the third vote is live rx_sync at N+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vote <= 2'b11;
    end else if (r_cnt == w_n - CNT_W'(1)) begin
      r_vote[0] <= w_rx_sync;
    end else if (r_cnt == w_n) begin
      r_vote[1] <= w_rx_sync;
    end
  end

  assign w_sample_pt = (r_cnt == w_n + CNT_W'(1));
  assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rx_sync) | (r_vote[1] & w_rx_sync);
`else
  assign w_sample_pt = (r_cnt == w_n);
  assign w_bit       = w_rx_sync;
`endif

  // Edge history; held off until the synchronizer carries real line data so
  // a line that is low when reset releases is not mistaken for a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_primed  <= 2'b00;
      r_rx_prev <= 1'b0;
    end else begin
      r_primed <= {r_primed[0], 1'b1};
      if (r_primed[1]) r_rx_prev <= w_rx_sync;
    end
  end

  assign w_fall = r_primed[1] & r_rx_prev & ~w_rx_sync;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_deliver    = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_next_state = ST_START;
          w_cnt_clr    = 1'b1;
        end
      end
      ST_START: begin
        if (w_sample_pt) begin
          w_cnt_clr    = 1'b1;
          w_next_state = w_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_sample_pt) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'(UART_DATA_BITS - 1)) w_next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_sample_pt) begin
          w_cnt_clr = 1'b1;
          if (w_bit) begin
            w_deliver    = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_next_state = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (w_rx_sync) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Bit-timing counter; parked at zero while waiting for a frame.
  always_ff @(posedge clk) begin
    if (rst)                                              r_cnt <= '0;
    else if (r_state == ST_IDLE || r_state == ST_WAIT_IDLE) r_cnt <= '0;
    else if (w_cnt_clr)                                   r_cnt <= CNT_RESTART;
    else                                                  r_cnt <= r_cnt + CNT_W'(1);
  end

  // LSB-first shift register and data bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_bit_cnt <= '0;
    end else if (w_shift_en) begin
      r_shift   <= {w_bit, r_shift[UART_DATA_BITS-1:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  assign w_consume = data_out_valid & data_out_ready;

  // Output register, valid/ready bookkeeping, and one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
      frame_error    <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      frame_error <= w_frame_err;
      overrun     <= 1'b0;
      if (w_deliver) begin
        if (data_out_valid && !data_out_ready) begin
          overrun <= 1'b1;
        end else begin
          data_out       <= r_shift;
          data_out_valid <= 1'b1;
        end
      end else if (w_consume) begin
        data_out_valid <= 1'b0;
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 95 MHz / 115200 baud (824
// cycles per bit). A driver pushes expected bytes into exp_q; a monitor
// pops and compares whenever the DUT hands over a byte.
module tb_uart_receiver;

  localparam int CLOCK_FREQ = 95_000_000;
  localparam int BAUD_RATE  = 115_200;
  localparam int BIT_CYC    = 824;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       frame_error;
  logic       overrun;
  logic [2:0] dbg_state;

  uart_receiver #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .frame_error    (frame_error),
    .overrun        (overrun),
    .o_dbg_state    (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  logic [7:0] exp_q[$];

  int n_ferr         = 0;
  int n_ovr          = 0;
  int n_deliv        = 0;
  int cur_len        = 0;
  int last_valid_len = 0;
  int stab_viol      = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v, input int n);
    serial_in = v;
    cycles(n);
  endtask

  // 8N1 frame; rst_bit pulses reset inside that data bit, glitch_bit flips
  // the line for one cycle at the middle of that data bit (-1 = none).
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int rst_bit, input int glitch_bit);
    send_bit(1'b0, BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        serial_in = b[i];
        cycles(BIT_CYC / 4);
        rst = 1'b1;
        cycles(4);
        rst = 1'b0;
        cycles(BIT_CYC - BIT_CYC / 4 - 4);
      end else if (i == glitch_bit) begin
        serial_in = b[i];
        cycles(BIT_CYC / 2);
        serial_in = ~b[i];
        cycles(1);
        serial_in = b[i];
        cycles(BIT_CYC - BIT_CYC / 2 - 1);
      end else begin
        send_bit(b[i], BIT_CYC);
      end
    end
    send_bit(stop_v, BIT_CYC);
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_len   = 0;
        prev_hold = 1'b0;
      end else begin
        if (frame_error) n_ferr++;
        if (overrun)     n_ovr++;
        if (data_out_valid) begin
          cur_len++;
          if (cur_len == 1) n_deliv++;
        end else if (cur_len > 0) begin
          last_valid_len = cur_len;
          cur_len = 0;
        end
        if (prev_hold && data_out_valid && data_out !== prev_data) stab_viol++;
        if (data_out_valid && data_out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", data_out);
          end else begin
            e = exp_q.pop_front();
            check("scoreboard_data", 32'(data_out), 32'(e));
          end
        end
        prev_hold = data_out_valid && !data_out_ready;
        prev_data = data_out;
      end
    end
  end

  // Directed stimulus.
  initial begin
    int d0, f0, o0;
    rst            = 1'b1;
    serial_in      = 1'b1;
    data_out_ready = 1'b0;
    cycles(5);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_valid", 32'(data_out_valid), 32'h0);
    check("reset_frame_error", 32'(frame_error), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);
    rst = 1'b0;
    cycles(20);

    // 0xA5 with ready held high.
    data_out_ready = 1'b1;
    d0 = n_deliv; f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, -1);
    cycles(40);
    check("a5_deliveries", 32'(n_deliv - d0), 32'd1);
    check("a5_valid_len", 32'(last_valid_len), 32'd1);
    check("a5_frame_error", 32'(n_ferr - f0), 32'd0);
    check("a5_overrun", 32'(n_ovr - o0), 32'd0);

    // 0x3C then 0x81 with ready low: second byte is dropped.
    data_out_ready = 1'b0;
    d0 = n_deliv; f0 = n_ferr; o0 = n_ovr;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1, -1);
    cycles(20);
    send_frame(8'h81, 1'b1, -1, -1);
    cycles(20);
    check("ovr_data_held", 32'(data_out), 32'h3C);
    check("ovr_valid_held", 32'(data_out_valid), 32'h1);
    check("ovr_pulses", 32'(n_ovr - o0), 32'd1);
    check("ovr_deliveries", 32'(n_deliv - d0), 32'd1);
    data_out_ready = 1'b1;
    cycles(3);
    check("ovr_valid_drop", 32'(data_out_valid), 32'h0);
    check("ovr_frame_error", 32'(n_ferr - f0), 32'd0);

    // 0x55 with a low stop bit, break, then 0x12.
    d0 = n_deliv; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h55, 1'b0, -1, -1);
    serial_in = 1'b0;
    cycles(2000);
    serial_in = 1'b1;
    cycles(50);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, -1, -1);
    cycles(40);
    check("ferr_pulses", 32'(n_ferr - f0), 32'd1);
    check("ferr_deliveries", 32'(n_deliv - d0), 32'd1);
    check("ferr_overrun", 32'(n_ovr - o0), 32'd0);

    // 100-cycle low glitch on an idle line.
    d0 = n_deliv; f0 = n_ferr; o0 = n_ovr;
    serial_in = 1'b0;
    cycles(100);
    serial_in = 1'b1;
    cycles(1000);
    check("glitch_deliveries", 32'(n_deliv - d0), 32'd0);
    check("glitch_frame_error", 32'(n_ferr - f0), 32'd0);
    check("glitch_overrun", 32'(n_ovr - o0), 32'd0);
    check("glitch_state_idle", 32'(dbg_state), 32'h0);

    // Reset inside 0xF0 (line high at bit 4, then line low at bit 1).
    d0 = n_deliv; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'hF0, 1'b1, 4, -1);
    cycles(20);
    check("rst_data_out_cleared", 32'(data_out), 32'h0);
    check("rst_valid_low", 32'(data_out_valid), 32'h0);
    send_frame(8'hF0, 1'b1, 1, -1);
    cycles(20);
    check("rst_no_delivery", 32'(n_deliv - d0), 32'd0);
    check("rst_no_frame_error", 32'(n_ferr - f0), 32'd0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, -1, -1);
    cycles(40);
    check("rst_then_0f_delivery", 32'(n_deliv - d0), 32'd1);
    check("rst_overrun", 32'(n_ovr - o0), 32'd0);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // One-cycle inverted glitch at mid-bit 3 of 0x96.
    d0 = n_deliv;
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, -1, 3);
    cycles(40);
    check("vote_delivery", 32'(n_deliv - d0), 32'd1);
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("data_stable_while_held", 32'(stab_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
